core_bus_arbiter: RTL
=====================

// Module: core_bus_arbiter
// PURPOSE
//  Shares one memory/peripheral slave port between three masters: debug (M2), core_ex data (M1), instruction fetch (M0).
//  Registers each granted request, holds it on the slave until ack or timeout, then returns data/ack to the owner.
//  Drives hold_flag_out to core_ctrl so the pipeline stalls while an EX access is outstanding.
//  Sits between core_ex/IF/debug and the bus slave.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   32   data width
//  TMO_CYC  255  cycles in BUSY without s_ack before the access is aborted with error (1..255)
// PORTS
//  clk           in   1        clock, all state on rising edge
//  rst           in   1        reset, asynchronous, active-low
//  m_req_in      in   3        per-master request [2]=DBG [1]=EX [0]=IF
//  m_we_in       in   3        per-master write enable
//  m_addr_in     in   3*ADDR_W per-master address, master k at [k*ADDR_W +: ADDR_W]
//  m_wdata_in    in   3*DATA_W per-master write data, same packing
//  m_ack_out     out  3        one-cycle ack pulse to the owning master
//  m_err_out     out  1        valid with ack: access timed out
//  m_rdata_out   out  DATA_W   read data, valid with ack, held until next ack
//  s_req_out     out  1        slave request
//  s_we_out      out  1        slave write enable
//  s_addr_out    out  ADDR_W   slave address
//  s_wdata_out   out  DATA_W   slave write data
//  s_rdata_in    in   DATA_W   slave read data, sampled with s_ack_in
//  s_ack_in      in   1        slave completion, single cycle
//  hold_flag_out out  1        to core_ctrl: 1 = stall pipeline
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; rr_last=IF; timeout counter=0. Reset mid-access drops s_req_out immediately; no ack issued.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: if any m_req_in bit set, pick winner, latch id/we/addr/wdata, -> BUSY. Else stay.
//  Winner: DBG always first; between EX and IF round-robin by rr_last (the one not served last wins if both request).
//  BUSY: s_req_out=1 with latched fields stable; cnt++ each cycle.
//   s_ack_in=1 -> capture s_rdata_in (0 for writes), err=0, -> DONE.
//   cnt==TMO_CYC and no ack -> rdata=0, err=1, s_req_out drops, -> DONE. Ack wins if both in same cycle.
//  DONE: m_ack_out[id]=1 one cycle, m_err_out=err; update rr_last if id is EX/IF; cnt=0; -> IDLE.
//  Min latency req->ack: 3 cycles (IDLE sample, BUSY with same-cycle ack, DONE). One-cycle bubble after DONE.
//  Masters hold req and fields stable until their ack; dropping req mid-access does not abort, ack still pulsed.
//  Re-asserted req in the cycle after ack is treated as a new access.
//  hold_flag_out = m_req_in[1] & ~m_ack_out[1]. Combinational, so the stall releases in the ack cycle.
//  Widths: cnt 8 bits, saturates at TMO_CYC. No address decode, no byte lanes: word-aligned, as issued by core_ex.
// STRUCTURE
//  defines.v additions: master ids (BUS_M_IF/EX/DBG), FSM state encoding (BUS_ST_IDLE/BUSY/DONE), HoldPipe alongside HoldNone.
//  Sub-module core_bus_prio_sel: combinational picker
//   inputs: req[2:0], rr_last
//   outputs: gnt_id[1:0], gnt_valid
//  Top holds the FSM, latches, counter and rr_last.
// TESTING
//  1. IF-only read, addr 0x100, slave acks 2 cycles after s_req with 0xDEADBEEF -> m_ack_out=001, m_rdata_out=0xDEADBEEF, err=0.
//  2. EX write, addr 0x200, wdata 0x12345678 -> s_we_out=1 with those fields until ack; hold_flag_out=1 until the ack cycle.
//  3. All three request in the same cycle, slave acks immediately -> grant order DBG, EX, IF, then EX/IF alternate while both held.
//  4. EX read, slave never acks, TMO_CYC=4 -> s_req_out high 4 cycles, then m_ack_out=010, m_err_out=1, m_rdata_out=0.
//  5. rst low during BUSY -> s_req_out=0 asynchronously, no m_ack_out; after release, first pending request is served from IDLE.
//  6. s_ack_in in the same cycle cnt hits TMO_CYC -> err=0, slave data returned.

Source files
------------

// File: rtl/core_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// core_bus_arbiter_pkg
//   Shared types for the three-master bus arbiter: master identifiers,
//   arbiter FSM state encoding, pipeline hold encoding, and a one-hot helper.
//   No ports; imported by core_bus_arbiter and core_bus_prio_sel.
// -----------------------------------------------------------------------------
package core_bus_arbiter_pkg;

    // Master identifiers double as bit positions in the per-master vectors.
    typedef enum logic [1:0] {
        BUS_M_IF  = 2'd0,
        BUS_M_EX  = 2'd1,
        BUS_M_DBG = 2'd2
    } bus_master_e;

    typedef enum logic [1:0] {
        BUS_ST_IDLE = 2'd0,
        BUS_ST_BUSY = 2'd1,
        BUS_ST_DONE = 2'd2
    } bus_state_e;

    typedef enum logic {
        HOLD_NONE = 1'b0,
        HOLD_PIPE = 1'b1
    } hold_flag_e;

    localparam int BUS_CNT_W = 8;

    function automatic logic [2:0] bus_onehot(input bus_master_e id);
        return 3'b001 << id;
    endfunction

endpackage

// File: rtl/core_bus_prio_sel.sv
// -----------------------------------------------------------------------------
// core_bus_prio_sel
//   Combinational winner picker. Debug always wins; between EX and IF the one
//   that was not served last wins when both request.
//   Ports:
//     req       in  3  per-master request, indexed by bus_master_e
//     rr_last   in  2  last EX/IF master that completed an access
//     gnt_id    out 2  winning master (meaningful only with gnt_valid)
//     gnt_valid out 1  at least one master is requesting
// -----------------------------------------------------------------------------
module core_bus_prio_sel
    import core_bus_arbiter_pkg::*;
(
    input  logic [2:0]  req,
    input  bus_master_e rr_last,
    output bus_master_e gnt_id,
    output logic        gnt_valid
);

    // NOTE: every output of an always_comb block gets a default first, so no
    // path through the if/else chain can leave it unassigned and infer a latch.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = BUS_M_IF;
        if (req[BUS_M_DBG]) begin
            gnt_id = BUS_M_DBG;
        end else if (req[BUS_M_EX] && req[BUS_M_IF]) begin
            gnt_id = (rr_last == BUS_M_EX) ? BUS_M_IF : BUS_M_EX;
        end else if (req[BUS_M_EX]) begin
            gnt_id = BUS_M_EX;
        end
    end

endmodule

// File: rtl/core_bus_arbiter.sv
// -----------------------------------------------------------------------------
// core_bus_arbiter
//   Shares one slave port between debug (M2), core_ex data (M1) and
//   instruction fetch (M0). A granted request is latched, held on the slave
//   until s_ack_in or timeout, then acknowledged to its owner for one cycle.
//   Ports:
//     clk, rst            clock; asynchronous active-low reset
//     m_req_in/m_we_in    per-master request / write enable ([2]=DBG [1]=EX [0]=IF)
//     m_addr_in           per-master address, master k at [k*ADDR_W +: ADDR_W]
//     m_wdata_in          per-master write data, same packing
//     m_ack_out           one-cycle ack pulse to the owning master
//     m_err_out           with ack: access timed out
//     m_rdata_out         read data, valid with ack, held until next ack
//     s_req_out/s_we_out  slave request / write enable
//     s_addr_out          slave address
//     s_wdata_out         slave write data
//     s_rdata_in/s_ack_in slave read data / single-cycle completion
//     hold_flag_out       to core_ctrl: stall while an EX access is pending
// -----------------------------------------------------------------------------
module core_bus_arbiter
    import core_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          m_req_in,
    input  logic [2:0]          m_we_in,
    input  logic [3*ADDR_W-1:0] m_addr_in,
    input  logic [3*DATA_W-1:0] m_wdata_in,
    output logic [2:0]          m_ack_out,
    output logic                m_err_out,
    output logic [DATA_W-1:0]   m_rdata_out,
    output logic                s_req_out,
    output logic                s_we_out,
    output logic [ADDR_W-1:0]   s_addr_out,
    output logic [DATA_W-1:0]   s_wdata_out,
    input  logic [DATA_W-1:0]   s_rdata_in,
    input  logic                s_ack_in,
    output logic                hold_flag_out
);

    localparam logic [BUS_CNT_W-1:0] TMO_LIM = BUS_CNT_W'(TMO_CYC);

    bus_state_e                 state_q, state_d;
    bus_master_e                id_q, id_d;
    bus_master_e                rr_last_q, rr_last_d;
    logic                       we_q, we_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [DATA_W-1:0]          wdata_q, wdata_d;
    logic [DATA_W-1:0]          rdata_q, rdata_d;
    logic                       err_q, err_d;
    logic [BUS_CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;

    bus_master_e                gnt_id;
    logic                       gnt_valid;

    core_bus_prio_sel u_prio_sel (
        .req       (m_req_in),
        .rr_last   (rr_last_q),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    // Saturating busy-cycle count; the timeout fires in the cycle the count
    // reaches TMO_CYC, so s_req_out is high for exactly TMO_CYC cycles.
    assign cnt_inc = (cnt_q == TMO_LIM) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        rr_last_d = rr_last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            BUS_ST_IDLE: begin
                if (gnt_valid) begin
                    id_d    = gnt_id;
                    we_d    = m_we_in[gnt_id];
                    addr_d  = m_addr_in[int'(gnt_id)*ADDR_W +: ADDR_W];
                    wdata_d = m_wdata_in[int'(gnt_id)*DATA_W +: DATA_W];
                    cnt_d   = '0;
                    state_d = BUS_ST_BUSY;
                end
            end
            BUS_ST_BUSY: begin
                cnt_d = cnt_inc;
                // Ack is checked first so a same-cycle ack beats the timeout.
                if (s_ack_in) begin
                    rdata_d = we_q ? '0 : s_rdata_in;
                    err_d   = 1'b0;
                    state_d = BUS_ST_DONE;
                end else if (cnt_inc == TMO_LIM) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = BUS_ST_DONE;
                end
            end
            BUS_ST_DONE: begin
                if (id_q != BUS_M_DBG) begin
                    rr_last_d = id_q;
                end
                cnt_d   = '0;
                state_d = BUS_ST_IDLE;
            end
            default: state_d = BUS_ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= BUS_ST_IDLE;
            id_q      <= BUS_M_IF;
            rr_last_q <= BUS_M_IF;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            rr_last_q <= rr_last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Slave request decodes straight from the state register, so an
    // asynchronous reset drops it without waiting for a clock edge.
    assign s_req_out   = (state_q == BUS_ST_BUSY);
    assign s_we_out    = we_q;
    assign s_addr_out  = addr_q;
    assign s_wdata_out = wdata_q;

    assign m_ack_out   = (state_q == BUS_ST_DONE) ? bus_onehot(id_q) : 3'b000;
    assign m_err_out   = (state_q == BUS_ST_DONE) & err_q;
    assign m_rdata_out = rdata_q;

    // Combinational so the stall releases in the ack cycle itself.
    assign hold_flag_out = (m_req_in[BUS_M_EX] & ~m_ack_out[BUS_M_EX]) ? HOLD_PIPE : HOLD_NONE;

endmodule
